dec_rr_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one 2x4 positive-output, negative-enable decoder among 4 requesters.
- Drives the decoder's 2-bit select and active-low enable from a registered FSM, and produces the matching one-hot grant vector.
- Sits between requesting blocks and the shared decoder; owns all sequencing of that decoder.

---
 rtl/dec_rr_arbiter.sv | 73 +++++++
 tb/tb_dec_rr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_rr_arbiter.sv
// dec_rr_arbiter: round-robin sequencer sharing one 2x4 active-low-enable decoder among 4 requesters (optional forced release via ARB_TIMEOUT_EN)
module dec_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       en_n,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       tmo
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t     state;
    logic [1:0] last;
    logic [1:0] win;
    logic       timeout;
    if (MAX_HOLD < 1 || MAX_HOLD > 255 || MAX_HOLD >= (1 << CNT_W)) begin : g_bad_param
        $error("dec_rr_arbiter: MAX_HOLD out of range for CNT_W");
    end
    // winner is the first requester after last, wrapping so last itself comes last
    always_comb begin
        win = last;
        for (int i = 3; i >= 0; i--)
            if (req[last + 2'(i) + 2'd1]) win = last + 2'(i) + 2'd1;
    end
`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    // holder has used its full budget and still wants the resource
    always_comb timeout = req[sel] && cnt == CNT_W'(MAX_HOLD - 1);
    // counts extra grant cycles of the current holder
    always_ff @(posedge clk)
        if (rst || state != GRANT) cnt <= '0;
        else cnt <= cnt + 1'b1;
`else
    // without the timeout feature a grant lasts as long as the request
    always_comb timeout = 1'b0;
`endif
    // sequencing FSM with all decoder controls and status registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'd0;
            en_n  <= 1'b1;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            tmo   <= 1'b0;
            last  <= 2'd3;
        end else begin
            tmo <= 1'b0;
            if (state == GRANT) begin
                if (!req[sel] || timeout) begin
                    state <= RELEASE;
                    en_n  <= 1'b1;
                    gnt   <= 4'b0000;
                    busy  <= 1'b0;
                    last  <= sel;
                    tmo   <= timeout;
                end
            end else if (|req) begin
                state <= GRANT;
                sel   <= win;
                en_n  <= 1'b0;
                gnt   <= 4'b0001 << win;
                busy  <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dec_rr_arbiter.sv
// tb_dec_rr_arbiter: directed scenarios plus randomized run against a round-robin reference model
module tb_dec_rr_arbiter;
    localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [1:0] sel;
    logic       en_n;
    logic [3:0] gnt;
    logic       busy;
    logic       tmo;
    int checks = 0;
    int errors = 0;

    dec_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .sel(sel),
        .en_n(en_n), .gnt(gnt), .busy(busy), .tmo(tmo)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(4'b0000);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(4'b1111);
            checks++;
            if ({gnt, en_n, busy, tmo} !== {4'b0000, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got gnt=%b en_n=%b busy=%b tmo=%b want gnt=0000 en_n=1 busy=0 tmo=0", c, gnt, en_n, busy, tmo);
            end
        end
        rst = 1'b0;
        step(4'b1111);
        checks++;
        if ({gnt, sel, en_n, busy} !== {4'b0001, 2'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_priority got gnt=%b sel=%0d en_n=%b busy=%b want gnt=0001 sel=0 en_n=0 busy=1", gnt, sel, en_n, busy);
        end
        step(4'b0000);
        step(4'b0000);
    endtask

    task automatic test_rotation();
        logic [3:0] exp;
        do_reset();
        step(4'b1111);
        for (int k = 0; k < 5; k++) begin
            exp = 4'b0001 << (k % 4);
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (gnt !== exp || en_n !== 1'b0) begin
                    errors++;
                    $display("FAIL rotation grant k=%0d c=%0d got gnt=%b en_n=%b want gnt=%b en_n=0", k, c, gnt, en_n, exp);
                end
                if (c < 2) step(4'b1111);
            end
            step(4'b1111 & ~exp);
            checks++;
            if (gnt !== 4'b0000 || en_n !== 1'b1) begin
                errors++;
                $display("FAIL rotation gap k=%0d got gnt=%b en_n=%b want gnt=0000 en_n=1", k, gnt, en_n);
            end
            step(4'b1111);
        end
        step(4'b0000);
        step(4'b0000);
    endtask

    task automatic test_no_preempt();
        do_reset();
        step(4'b0100);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (gnt !== 4'b0100 || sel !== 2'd2) begin
                errors++;
                $display("FAIL no_preempt hold c=%0d got gnt=%b sel=%0d want gnt=0100 sel=2", c, gnt, sel);
            end
            if (c < 2) step(4'b0101);
        end
        step(4'b0001);
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_preempt release got gnt=%b busy=%b want gnt=0000 busy=0", gnt, busy);
        end
        step(4'b0001);
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            errors++;
            $display("FAIL no_preempt next got gnt=%b sel=%0d want gnt=0001 sel=0", gnt, sel);
        end
        step(4'b0000);
        step(4'b0000);
    endtask

    task automatic test_one_cycle();
        do_reset();
        step(4'b0000);
        step(4'b1000);
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3 || en_n !== 1'b0) begin
            errors++;
            $display("FAIL one_cycle grant got gnt=%b sel=%0d en_n=%b want gnt=1000 sel=3 en_n=0", gnt, sel, en_n);
        end
        step(4'b0000);
        checks++;
        if (gnt !== 4'b0000 || en_n !== 1'b1 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL one_cycle release got gnt=%b en_n=%b tmo=%b want gnt=0000 en_n=1 tmo=0", gnt, en_n, tmo);
        end
        step(4'b0000);
        checks++;
        if (gnt !== 4'b0000 || en_n !== 1'b1 || busy !== 1'b0 || sel !== 2'd3) begin
            errors++;
            $display("FAIL one_cycle idle got gnt=%b en_n=%b busy=%b sel=%0d want gnt=0000 en_n=1 busy=0 sel=3", gnt, en_n, busy, sel);
        end
    endtask

    task automatic test_timeout();
        int hold_len;
        do_reset();
        hold_len = TMO_ON ? MH : MH + 6;
        step(4'b0110);
        for (int c = 0; c < hold_len; c++) begin
            checks++;
            if (gnt !== 4'b0010 || tmo !== 1'b0) begin
                errors++;
                $display("FAIL timeout hold c=%0d got gnt=%b tmo=%b want gnt=0010 tmo=0", c, gnt, tmo);
            end
            step(4'b0110);
        end
        if (TMO_ON) begin
            checks++;
            if (gnt !== 4'b0000 || tmo !== 1'b1) begin
                errors++;
                $display("FAIL timeout pulse got gnt=%b tmo=%b want gnt=0000 tmo=1", gnt, tmo);
            end
            step(4'b0110);
            checks++;
            if (gnt !== 4'b0100 || tmo !== 1'b0) begin
                errors++;
                $display("FAIL timeout next got gnt=%b tmo=%b want gnt=0100 tmo=0", gnt, tmo);
            end
        end else begin
            checks++;
            if (gnt !== 4'b0010 || tmo !== 1'b0) begin
                errors++;
                $display("FAIL timeout disabled got gnt=%b tmo=%b want gnt=0010 tmo=0", gnt, tmo);
            end
        end
        step(4'b0000);
        step(4'b0000);
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        step(4'b0100);
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL midrst setup got gnt=%b want 0100", gnt);
        end
        rst = 1'b1;
        step(4'b0100);
        checks++;
        if (gnt !== 4'b0000 || en_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst drop got gnt=%b en_n=%b busy=%b want gnt=0000 en_n=1 busy=0", gnt, en_n, busy);
        end
        rst = 1'b0;
        step(4'b1111);
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            errors++;
            $display("FAIL midrst first got gnt=%b sel=%0d want gnt=0001 sel=0", gnt, sel);
        end
        step(4'b0000);
        step(4'b0000);
    endtask

    // reference: who holds the resource, how long it has held it, who was served last
    task automatic test_random();
        bit         granted = 0, in_gap = 0, m_tmo = 0;
        int         holder = 0, held = 0, last_served = 3;
        logic [3:0] r, exp_gnt;
        bit         r_rst;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = 4'($urandom);
            if (granted && $urandom_range(7) != 0) r[holder] = 1'b1;
            if ($urandom_range(3) == 0) r = 4'b0000;
            r_rst = ($urandom_range(199) == 0);
            rst = r_rst;
            step(r);
            m_tmo = 0;
            if (r_rst) begin
                granted = 0; in_gap = 0; holder = 0; held = 0; last_served = 3;
            end else if (granted) begin
                if (!r[holder] || (TMO_ON && held == MH)) begin
                    m_tmo = TMO_ON && r[holder] && held == MH;
                    last_served = holder;
                    granted = 0;
                    in_gap = 1;
                end else begin
                    held++;
                end
            end else begin
                in_gap = 0;
                if (r != 0) begin
                    for (int d = 1; d <= 4; d++) begin
                        if (!granted && r[(last_served + d) % 4]) begin
                            holder = (last_served + d) % 4;
                            granted = 1;
                        end
                    end
                    held = 1;
                end
            end
            exp_gnt = granted ? 4'(1 << holder) : 4'b0000;
            checks++;
            if ({gnt, sel, en_n, busy, tmo} !== {exp_gnt, 2'(holder), !granted, granted, m_tmo}) begin
                errors++;
                $display("FAIL random n=%0d req=%b got gnt=%b sel=%0d en_n=%b busy=%b tmo=%b want gnt=%b sel=%0d en_n=%b busy=%b tmo=%b",
                         n, r, gnt, sel, en_n, busy, tmo, exp_gnt, holder, !granted, granted, m_tmo);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_no_preempt();
        test_one_cycle();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
